// File: rtl/cpu_timing_pkg.sv
// Shared types and constants for the 19-bit CPU sequence/timing control block.
package cpu_timing_pkg;

    localparam int NUM_T = 7;
    localparam int SC_W  = 3;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(NUM_T - 1);

    typedef enum logic [2:0] {
        HALT      = 3'd0,
        RUN       = 3'd1,
        WAIT      = 3'd2,
        STEP_HOLD = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_SEQ_OVR = 2'b01;
    localparam logic [1:0] FLT_MEM_TO  = 2'b10;

    // One-hot timing vector for a given sequence count.
    function automatic logic [NUM_T-1:0] t_decode(input logic [SC_W-1:0] sc);
        logic [NUM_T-1:0] one;
        one = {{(NUM_T-1){1'b0}}, 1'b1};
        return one << sc;
    endfunction

endpackage

// File: rtl/seq_timing_ctrl_wait_timer.sv
// Memory wait-state counter: loads 1 on entry to WAIT, counts up, flags the limit.
module wait_timer #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic expired
);

    logic [W-1:0] count_r;

    // Wait-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= W'(1);
        end else if (inc) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == W'(MAX));

endmodule

// File: rtl/seq_timing_ctrl.sv
// Sequence counter and run control: T0..T6 generation, memory wait states,
// run/halt/single-step at instruction boundaries, overrun and timeout faults.
module seq_timing_ctrl
    import cpu_timing_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              step_mode,
    input  logic              step_pulse,
    input  logic              sc_clr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              mem_ready,
    output logic [NUM_T-1:0]  t,
    output logic [SC_W-1:0]   sc_value,
    output logic              running,
    output logic              halted,
    output logic              wait_active,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [ICNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t            state_r, state_next_s;
    logic [SC_W-1:0]   sc_r, sc_next_s;
    logic              fault_r, fault_next_s;
    logic [1:0]        code_r, code_next_s;
    logic [ICNT_W-1:0] icnt_r;
    logic              icnt_inc_s;
    logic              wt_load_s, wt_inc_s, wt_expired_s;

    state_t            adv_state_s;
    logic [SC_W-1:0]   adv_sc_s;
    logic              adv_boundary_s, adv_ovr_s;

    logic [NUM_T-1:0]  t_r, t_next_s;
    logic              running_r, running_next_s;
    logic              halted_r, halted_next_s;
    logic              wait_r, wait_next_s;

    wait_timer #(.MAX(WAIT_MAX), .W(WAIT_W)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wt_load_s),
        .inc     (wt_inc_s),
        .expired (wt_expired_s)
    );

    // State, sequence count, fault and retired-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HALT;
            sc_r    <= {SC_W{1'b0}};
            fault_r <= 1'b0;
            code_r  <= FLT_NONE;
            icnt_r  <= {ICNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            sc_r    <= sc_next_s;
            fault_r <= fault_next_s;
            code_r  <= code_next_s;
            icnt_r  <= icnt_inc_s ? icnt_r + ICNT_W'(1) : icnt_r;
        end
    end

    // Rules 2-4 of a RUN cycle, shared by RUN and a completing WAIT.
    always_comb begin
        adv_state_s    = RUN;
        adv_sc_s       = sc_r;
        adv_boundary_s = 1'b0;
        adv_ovr_s      = 1'b0;
        if (sc_clr) begin
            adv_boundary_s = 1'b1;
            adv_sc_s       = {SC_W{1'b0}};
            if (halt_req) begin
                adv_state_s = HALT;
            end else if (step_mode) begin
                adv_state_s = STEP_HOLD;
            end else begin
                adv_state_s = RUN;
            end
        end else if (sc_r == SC_LAST) begin
            adv_state_s = FAULT;
            adv_sc_s    = {SC_W{1'b0}};
            adv_ovr_s   = 1'b1;
        end else begin
            adv_sc_s = sc_r + SC_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        sc_next_s    = sc_r;
        fault_next_s = fault_r;
        code_next_s  = code_r;
        icnt_inc_s   = 1'b0;
        wt_load_s    = 1'b0;
        wt_inc_s     = 1'b0;
        case (state_r)
            HALT: begin
                if (start) begin
                    state_next_s = RUN;
                    sc_next_s    = {SC_W{1'b0}};
                end else begin
                    state_next_s = HALT;
                end
            end
            RUN, WAIT: begin
                if (state_r == RUN && (mem_rd || mem_wr) && !mem_ready) begin
                    state_next_s = WAIT;
                    wt_load_s    = 1'b1;
                end else if (state_r == RUN || mem_ready) begin
                    state_next_s = adv_state_s;
                    sc_next_s    = adv_sc_s;
                    icnt_inc_s   = adv_boundary_s;
                    if (adv_ovr_s) begin
                        fault_next_s = 1'b1;
                        code_next_s  = FLT_SEQ_OVR;
                    end else begin
                        fault_next_s = fault_r;
                    end
                end else if (wt_expired_s) begin
                    state_next_s = FAULT;
                    sc_next_s    = {SC_W{1'b0}};
                    fault_next_s = 1'b1;
                    code_next_s  = FLT_MEM_TO;
                end else begin
                    wt_inc_s = 1'b1;
                end
            end
            STEP_HOLD: begin
                sc_next_s = {SC_W{1'b0}};
                if (halt_req) begin
                    state_next_s = HALT;
                end else if (step_pulse) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = STEP_HOLD;
                end
            end
            FAULT: begin
                sc_next_s = {SC_W{1'b0}};
                if (start) begin
                    state_next_s = RUN;
                    fault_next_s = 1'b0;
                    code_next_s  = FLT_NONE;
                end else begin
                    state_next_s = FAULT;
                end
            end
            default: begin
                state_next_s = HALT;
                sc_next_s    = {SC_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state, so the outputs can be registered.
    always_comb begin
        t_next_s       = {NUM_T{1'b0}};
        running_next_s = 1'b0;
        halted_next_s  = 1'b0;
        wait_next_s    = 1'b0;
        if (state_next_s == RUN || state_next_s == WAIT) begin
            t_next_s       = t_decode(sc_next_s);
            running_next_s = 1'b1;
        end else begin
            t_next_s = {NUM_T{1'b0}};
        end
        halted_next_s = (state_next_s == HALT);
        wait_next_s   = (state_next_s == WAIT);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r       <= {NUM_T{1'b0}};
            running_r <= 1'b0;
            halted_r  <= 1'b1;
            wait_r    <= 1'b0;
        end else begin
            t_r       <= t_next_s;
            running_r <= running_next_s;
            halted_r  <= halted_next_s;
            wait_r    <= wait_next_s;
        end
    end

    assign t           = t_r;
    assign sc_value    = sc_r;
    assign running     = running_r;
    assign halted      = halted_r;
    assign wait_active = wait_r;
    assign fault       = fault_r;
    assign fault_code  = code_r;
    assign instr_cnt   = icnt_r;

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Scoreboard bench for seq_timing_ctrl: directed per-cycle vectors, queued expectations.
module tb_seq_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, step_mode = 1'b0, step_pulse = 1'b0;
    logic        sc_clr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, mem_ready = 1'b0;
    logic [6:0]  t;
    logic [2:0]  sc_value;
    logic        running, halted, wait_active, fault;
    logic [1:0]  fault_code;
    logic [15:0] instr_cnt;

    seq_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step_pulse(step_pulse), .sc_clr(sc_clr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .t(t), .sc_value(sc_value), .running(running), .halted(halted),
        .wait_active(wait_active), .fault(fault), .fault_code(fault_code),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Input bit masks: {start,halt_req,step_mode,step_pulse,sc_clr,mem_rd,mem_wr,mem_ready}
    localparam logic [7:0] S = 8'h80, H = 8'h40, SM = 8'h20, SP = 8'h10;
    localparam logic [7:0] C = 8'h08, RD = 8'h04, WR = 8'h02, RDY = 8'h01, NONE = 8'h00;
    localparam int E_HALT = 0, E_RUN = 1, E_WAIT = 2, E_STEP = 3, E_FAULT = 4;

    typedef struct {
        logic [6:0]  t;
        logic [2:0]  sc;
        logic        chk_sc;
        logic        run, hlt, wa, flt;
        logic [1:0]  code;
        logic [15:0] icnt;
        string       nm;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic        exp_fault = 1'b0;
    logic [1:0]  exp_code = 2'b00;
    logic [15:0] exp_icnt = 16'h0000;

    function automatic logic [2:0] onehot_idx(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 7; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic apply(input logic [7:0] in);
        @(negedge clk);
        {start, halt_req, step_mode, step_pulse, sc_clr, mem_rd, mem_wr, mem_ready} = in;
    endtask

    task automatic step(input logic [7:0] in, input logic [6:0] et, input int est, input string nm);
        exp_t e;
        apply(in);
        e.t      = et;
        e.sc     = onehot_idx(et);
        e.chk_sc = (est == E_RUN || est == E_WAIT);
        e.run    = (est == E_RUN || est == E_WAIT);
        e.hlt    = (est == E_HALT);
        e.wa     = (est == E_WAIT);
        e.flt    = exp_fault;
        e.code   = exp_code;
        e.icnt   = exp_icnt;
        e.nm     = nm;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per registered output update and compares.
    initial begin
        exp_t e;
        logic [28:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {t, running, halted, wait_active, fault, fault_code, instr_cnt};
                req = {e.t, e.run, e.hlt, e.wa, e.flt, e.code, e.icnt};
                total++;
                if (act !== req || (e.chk_sc && sc_value !== e.sc)) begin
                    bad++;
                    $display("FAIL %s: got t=%h run=%b hlt=%b wait=%b flt=%b code=%b icnt=%h sc=%0d ; want t=%h run=%b hlt=%b wait=%b flt=%b code=%b icnt=%h sc=%0d",
                             e.nm, t, running, halted, wait_active, fault, fault_code, instr_cnt, sc_value,
                             e.t, e.run, e.hlt, e.wa, e.flt, e.code, e.icnt, e.sc);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        step(NONE, 7'h00, E_HALT, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic instruction, zero-wait memory read at T1, sc_clr at T3
        step(S,        7'h01, E_RUN, "start_t0");
        step(NONE,     7'h02, E_RUN, "t1");
        step(RD | RDY, 7'h04, E_RUN, "zero_wait");
        step(NONE,     7'h08, E_RUN, "t3");
        exp_icnt++;
        step(C,        7'h01, E_RUN, "boundary1");

        // Three wait states at T1
        step(NONE,     7'h02, E_RUN,  "w_t1");
        step(RD,       7'h02, E_WAIT, "w_enter");
        step(RD,       7'h02, E_WAIT, "w_hold1");
        step(RD,       7'h02, E_WAIT, "w_hold2");
        step(RD | RDY, 7'h04, E_RUN,  "w_done");
        exp_icnt++;
        step(C,        7'h01, E_RUN,  "boundary2");

        // Memory timeout: 15 wait cycles then fault
        step(NONE, 7'h02, E_RUN,  "to_t1");
        step(WR,   7'h02, E_WAIT, "to_enter");
        for (int i = 0; i < 14; i++) step(WR, 7'h02, E_WAIT, "to_wait");
        exp_fault = 1'b1; exp_code = 2'b10;
        step(WR,   7'h00, E_FAULT, "to_fault");
        step(NONE, 7'h00, E_FAULT, "to_hold");
        exp_fault = 1'b0; exp_code = 2'b00;
        step(S,    7'h01, E_RUN,   "to_restart");

        // start ignored in RUN, mem_ready alone ignored
        step(S,    7'h02, E_RUN, "start_ign");
        step(RDY,  7'h04, E_RUN, "rdy_ign");
        exp_icnt++;
        step(C,    7'h01, E_RUN, "boundary3");

        // Sequence overrun after T6
        step(NONE, 7'h02, E_RUN, "ov_t1");
        step(NONE, 7'h04, E_RUN, "ov_t2");
        step(NONE, 7'h08, E_RUN, "ov_t3");
        step(NONE, 7'h10, E_RUN, "ov_t4");
        step(NONE, 7'h20, E_RUN, "ov_t5");
        step(NONE, 7'h40, E_RUN, "ov_t6");
        exp_fault = 1'b1; exp_code = 2'b01;
        step(NONE, 7'h00, E_FAULT, "ov_fault");
        exp_fault = 1'b0; exp_code = 2'b00;
        step(S,    7'h01, E_RUN,   "ov_restart");

        // Single-step mode
        step(SM,      7'h02, E_RUN, "st_t1");
        exp_icnt++;
        step(SM | C,  7'h00, E_STEP, "st_hold1");
        step(SM,      7'h00, E_STEP, "st_wait");
        step(SM | S,  7'h00, E_STEP, "st_start_ign");
        step(SM | SP, 7'h01, E_RUN,  "st_release");
        exp_icnt++;
        step(SM | C,  7'h00, E_STEP, "st_hold2");
        step(SP,      7'h01, E_RUN,  "st_release2");

        // halt_req at T1 of a 5-state instruction
        step(NONE,  7'h02, E_RUN, "h_t1");
        step(H,     7'h04, E_RUN, "h_t2");
        step(H,     7'h08, E_RUN, "h_t3");
        step(H,     7'h10, E_RUN, "h_t4");
        exp_icnt++;
        step(H | C, 7'h00, E_HALT, "h_halted");
        step(SP | C | RD | RDY | H, 7'h00, E_HALT, "h_ignore");
        step(S,     7'h01, E_RUN, "h_restart");
        exp_icnt++;
        step(H | SM | C, 7'h00, E_HALT, "h_over_step");
        step(S,     7'h01, E_RUN, "h_restart2");
        exp_icnt++;
        step(SM | C, 7'h00, E_STEP, "h_step_hold");
        step(H | SP, 7'h00, E_HALT, "h_prio");
        step(S,     7'h01, E_RUN, "h_restart3");

        // instr_cnt wrap: retire single-cycle instructions up to FFFE unchecked
        n = int'(16'hFFFE - exp_icnt);
        for (int i = 0; i < n; i++) apply(C);
        exp_icnt = 16'hFFFE;
        exp_icnt++;
        step(C, 7'h01, E_RUN, "icnt_ffff");
        exp_icnt++;
        step(C, 7'h01, E_RUN, "icnt_wrap");

        // Reset in the middle of a wait
        step(NONE, 7'h02, E_RUN,  "r_t1");
        step(RD,   7'h02, E_WAIT, "r_wait");
        @(negedge clk);
        rst_n = 1'b0;
        {start, halt_req, step_mode, step_pulse, sc_clr, mem_rd, mem_wr, mem_ready} = NONE;
        #1;
        total++;
        if (t !== 7'h00 || halted !== 1'b1 || wait_active !== 1'b0 || running !== 1'b0 ||
            instr_cnt !== 16'h0000 || sc_value !== 3'd0) begin
            bad++;
            $display("FAIL async_reset: got t=%h hlt=%b wait=%b run=%b icnt=%h sc=%0d ; want t=00 hlt=1 wait=0 run=0 icnt=0000 sc=0",
                     t, halted, wait_active, running, instr_cnt, sc_value);
        end
        exp_icnt = 16'h0000;
        step(NONE, 7'h00, E_HALT, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(S, 7'h01, E_RUN, "post_reset_start");

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending ; want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
